// File: rtl/bram_burst_reader_pkg.sv
// Shared definitions for the BRAM burst reader and users of the BRAM wrapper.
package bram_burst_reader_pkg;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  typedef logic [DEF_DATA_WIDTH-1:0] line_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] line_idx_t;

endpackage

// File: rtl/bram_burst_reader_stream_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module stream_sync_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage is not reset: contents are only observable once counted in.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read master for a 1-cycle registered-read BRAM port, delivering lines on a
// valid/ready stream; issue is credit-limited so returning data always has a FIFO slot.
module bram_burst_reader
  import bram_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  last_tag_q, last_tag_d;

  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [CW:0]           credit;
  logic                  pop;
  logic                  issue;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;

  // A beat popped this cycle frees its slot in time for a read issued now.
  assign credit = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue  = (state_q == ISSUE) && !abort && (credit < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      last_tag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      last_tag_q  <= last_tag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
    last_tag_d  = last_tag_q;
    if (abort) begin
      state_d    = IDLE;
      inflight_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_d     = ISSUE;
            ptr_d       = req_addr;
            remaining_d = req_len;
          end
        end
        ISSUE: begin
          if (issue) begin
            ptr_d       = ptr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - ADDR_WIDTH'(1);
            last_tag_d  = (remaining_q == '0);
            if (remaining_q == '0) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  stream_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .flush_i     (abort),
    .push_i      (inflight_q),
    .push_data_i ({last_tag_q, bram_rdata}),
    .pop_i       (pop),
    .pop_data_o  (fifo_rdata),
    .count_o     (fifo_count)
  );

  assign req_ready  = (state_q == IDLE);
  assign bram_raddr = ptr_q;
  assign out_data   = fifo_rdata[DATA_WIDTH-1:0];
  assign out_last   = out_valid & fifo_rdata[DATA_WIDTH];
  assign busy       = (state_q != IDLE) | inflight_q | out_valid;

endmodule
